mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 88 ++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between the two client sides, the arbiter and the shared memory.
interface mem_arbiter_if;
    logic        hlt;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ready;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    modport master (
        output hlt, i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_enable, mem_wr, mem_addr, mem_data_in
    );
    modport slave (
        input  hlt, i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
        output i_ready, i_rdata, d_ready, d_rdata, mem_enable, mem_wr, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between instruction and data sides,
// data first, with a starve counter that forces an instruction grant after two data wins.
module mem_arbiter #(
    parameter int LATENCY = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
    localparam logic [3:0] LAT  = 4'(LATENCY);
    localparam logic       FAST = (LATENCY == 1);
    state_t      r_state;
    logic [1:0]  r_starve;
    logic [3:0]  r_cnt;
    logic        r_d_wr;
    logic        r_i_ready;
    logic        r_d_ready;
    logic        r_mem_enable;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_data_in;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;
    logic        w_idle;
    logic        w_grant_i;
    logic        w_grant_d;
    assign w_idle    = (r_state == IDLE) && !bus.hlt;
    assign w_grant_i = w_idle && bus.i_req && (r_starve == 2'd2 || !bus.d_req);
    assign w_grant_d = w_idle && bus.d_req && !w_grant_i;
    // ready is registered one edge early so it lands on the cycle the counter reads 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_starve      <= 2'd0;
            r_cnt         <= 4'd0;
            r_d_wr        <= 1'b0;
            r_i_ready     <= 1'b0;
            r_d_ready     <= 1'b0;
            r_mem_enable  <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= 16'd0;
            r_mem_data_in <= 16'd0;
            r_i_rdata     <= 16'd0;
            r_d_rdata     <= 16'd0;
        end else begin
            r_mem_enable <= w_grant_i || w_grant_d;
            r_mem_wr     <= w_grant_d && bus.d_wr;
            r_i_ready    <= (w_grant_i && FAST) || (r_state == I_BUSY && r_cnt == 4'd2);
            r_d_ready    <= (w_grant_d && FAST) || (r_state == D_BUSY && r_cnt == 4'd2);
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state    <= I_BUSY;
                        r_starve   <= 2'd0;
                        r_mem_addr <= bus.i_addr;
                        r_cnt      <= LAT;
                    end else if (w_grant_d) begin
                        r_state       <= D_BUSY;
                        r_starve      <= bus.i_req ? r_starve + 2'd1 : 2'd0;
                        r_mem_addr    <= bus.d_addr;
                        r_mem_data_in <= bus.d_wdata;
                        r_d_wr        <= bus.d_wr;
                        r_cnt         <= LAT;
                    end else if (!bus.i_req) begin
                        r_starve <= 2'd0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= IDLE;
                        if (r_state == I_BUSY) r_i_rdata <= bus.mem_data_out;
                        else if (!r_d_wr) r_d_rdata <= bus.mem_data_out;
                    end
                end
            endcase
        end
    end
    assign bus.i_ready     = r_i_ready;
    assign bus.d_ready     = r_d_ready;
    assign bus.i_rdata     = r_i_ready ? bus.mem_data_out : r_i_rdata;
    assign bus.d_rdata     = (r_d_ready && !r_d_wr) ? bus.mem_data_out : r_d_rdata;
    assign bus.mem_enable  = r_mem_enable;
    assign bus.mem_wr      = r_mem_wr;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_data_in;
endmodule
